// File: rtl/alarm_countdown_timer.sv
// Purpose: programmable seconds countdown for the alarm FSM, plus the 1 Hz tick and 0.5 Hz tone.
// Latency: start sampled in cycle N -> LOAD in N+1; expiry pulse in N+value*CLK_FREQ_HZ+1 (N+2 if value=0).
// Backpressure: none; start_timer is a request that always wins and restarts the countdown.
module alarm_countdown_timer #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [3:0] value,
    output logic       expired,
    output logic       one_hz_enable,
    output logic       half_hz_enable,
    output logic [3:0] value_display,
    output logic [1:0] timer_state
);

    // Prescaler only needs to hold 0..CLK_FREQ_HZ-1.
    localparam int            PRE_W  = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    // Encodings double as the display digit for the state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COUNT   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    logic [PRE_W-1:0] prescaler;
    logic             tick;
    logic             half_q;
    state_t           state;
    state_t           state_nxt;
    logic [3:0]       remaining;
    logic [3:0]       remaining_nxt;
    logic             remaining_le1;

    // Terminal count of the prescaler marks the one-second boundary.
    assign tick          = (prescaler == PRE_TC);
    assign remaining_le1 = (remaining <= 4'd1);

    // Free-running second prescaler; a start realigns it so the first tick is a full second away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (start_timer || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_ONE;
        end
    end

    // Tone square wave flips on every second boundary; starting the timer leaves its phase alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_q <= 1'b0;
        end else if (tick) begin
            half_q <= ~half_q;
        end
    end

    // State and remaining-seconds registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= 4'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state logic; a start request overrides whatever the current state decided.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                state_nxt = (remaining == 4'd0) ? ST_EXPIRED : ST_COUNT;
            end
            ST_COUNT: begin
                if (tick) begin
                    // Saturate at zero so a stray zero count can never wrap to 15.
                    if (remaining_le1) begin
                        remaining_nxt = 4'd0;
                        state_nxt     = ST_EXPIRED;
                    end else begin
                        remaining_nxt = remaining - 4'd1;
                    end
                end
            end
            ST_EXPIRED: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt     = ST_IDLE;
                remaining_nxt = 4'd0;
            end
        endcase
        if (start_timer) begin
            state_nxt     = ST_LOAD;
            remaining_nxt = value;
        end
    end

    // Outputs are all state-decoded or registered, so reset clears them immediately.
    always_comb begin
        expired        = (state == ST_EXPIRED);
        one_hz_enable  = tick;
        half_hz_enable = half_q;
        value_display  = remaining;
        timer_state    = state;
    end

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Purpose: self-checking bench for alarm_countdown_timer with a cycle-level behavioural model.
// Latency: outputs compared #1 after each rising edge against the model's view of that cycle.
// Backpressure: not applicable; the bench drives start_timer freely.
module tb_alarm_countdown_timer;

    localparam int F = 4;

    logic       clock;
    logic       reset;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;
    logic       one_hz_enable;
    logic       half_hz_enable;
    logic [3:0] value_display;
    logic [1:0] timer_state;

    alarm_countdown_timer #(.CLK_FREQ_HZ(F)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_timer    (start_timer),
        .value          (value),
        .expired        (expired),
        .one_hz_enable  (one_hz_enable),
        .half_hz_enable (half_hz_enable),
        .value_display  (value_display),
        .timer_state    (timer_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state: cycle index, last start cycle/value, prescaler alignment, tone level.
    int   cyc;
    int   ls;
    int   lv;
    int   ref_c;
    logic half_m;
    int   exp_cnt;
    int   last_exp;
    int   hz_cnt;

    typedef struct {
        logic       s;
        logic [3:0] v;
        int         st;
        int         ex;
        int         disp;
        int         hz;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic int tick_at(input int c);
        return ((c > ref_c) && (((c - ref_c) % F) == 0)) ? 1 : 0;
    endfunction

    // Expected countdown outputs from the timing rules: everything follows from the last start.
    task automatic model(input int c, output int st, output int ex, output int disp);
        int d;
        st = 0; ex = 0; disp = 0;
        if (ls >= 0) begin
            d = c - ls;
            if (d == 1) begin
                st = 1; disp = lv;
            end else if (lv == 0) begin
                if (d == 2) begin st = 3; ex = 1; end
            end else if (d <= lv * F) begin
                st = 2; disp = lv - (d - 1) / F;
            end else if (d == lv * F + 1) begin
                st = 3; ex = 1;
            end
        end
    endtask

    task automatic check_now();
        int st, ex, disp;
        model(cyc, st, ex, disp);
        chk("timer_state", int'(timer_state), st);
        chk("expired", int'(expired), ex);
        chk("value_display", int'(value_display), disp);
        chk("one_hz_enable", int'(one_hz_enable), tick_at(cyc));
        chk("half_hz_enable", int'(half_hz_enable), int'(half_m));
        if (expired) begin exp_cnt++; last_exp = cyc; end
        if (one_hz_enable) hz_cnt++;
    endtask

    task automatic step(input logic s, input logic [3:0] v);
        start_timer = s;
        value       = v;
        @(posedge clock);
        #1;
        if (tick_at(cyc) != 0) half_m = ~half_m;
        if (s) begin ls = cyc; lv = int'(v); ref_c = cyc; end
        cyc++;
        check_now();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
    task automatic do_reset();
        start_timer = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_expired", int'(expired), 0);
        chk("rst_state", int'(timer_state), 0);
        chk("rst_display", int'(value_display), 0);
        chk("rst_one_hz", int'(one_hz_enable), 0);
        chk("rst_half_hz", int'(half_hz_enable), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc++;
        ls = -1; ref_c = cyc - 1; half_m = 1'b0;
        check_now();
    endtask

    initial begin
        int n;
        reset = 1'b1; start_timer = 1'b0; value = 4'd0;
        cyc = 0; ls = -1; lv = 0; ref_c = -1; half_m = 1'b0;
        exp_cnt = 0; last_exp = -1; hz_cnt = 0;

        // Directed table: value=0 immediate expiry, then value=3 full countdown.
        tbl[0] = '{1'b1, 4'd0, 1, 0, 0, 0};
        tbl[1] = '{1'b0, 4'd0, 3, 1, 0, 0};
        tbl[2] = '{1'b0, 4'd0, 0, 0, 0, 0};
        tbl[3] = '{1'b1, 4'd3, 1, 0, 3, 0};
        for (int d = 2; d <= 14; d++) begin
            int st, ex, dp, hz;
            st = 2; ex = 0; hz = (d % 4 == 0) ? 1 : 0;
            dp = (d <= 4) ? 3 : (d <= 8) ? 2 : 1;
            if (d == 13) begin st = 3; ex = 1; dp = 0; hz = 0; end
            if (d == 14) begin st = 0; dp = 0; hz = 0; end
            tbl[d + 2] = '{1'b0, 4'd0, st, ex, dp, hz};
        end

        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_now();

        // Idle after reset: tick every F cycles, never an expiry.
        idle(20);
        chk("idle_hz_pulses", hz_cnt, 5);
        chk("idle_expired", exp_cnt, 0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s, tbl[i].v);
            chk("tbl_state", int'(timer_state), tbl[i].st);
            chk("tbl_expired", int'(expired), tbl[i].ex);
            chk("tbl_display", int'(value_display), tbl[i].disp);
            chk("tbl_one_hz", int'(one_hz_enable), tbl[i].hz);
        end

        // Restart mid-count: only the second countdown expires.
        idle(3);
        exp_cnt = 0;
        n = cyc;
        step(1'b1, 4'd5);
        idle(8);
        step(1'b1, 4'd2);
        idle(16);
        chk("restart_exp_count", exp_cnt, 1);
        chk("restart_exp_cycle", last_exp - n, 18);

        // Start pulsed during the expiry cycle chains a second countdown.
        exp_cnt = 0;
        n = cyc;
        step(1'b1, 4'd1);
        idle(4);
        chk("chain_first_exp", int'(expired), 1);
        n = cyc;
        step(1'b1, 4'd1);
        chk("chain_load", int'(timer_state), 1);
        idle(6);
        chk("chain_exp_count", exp_cnt, 2);
        chk("chain_exp_cycle", last_exp - n, 5);

        // Reset while two seconds remain: no expiry afterwards.
        step(1'b1, 4'd3);
        idle(6);
        chk("pre_reset_display", int'(value_display), 2);
        do_reset();
        exp_cnt = 0;
        idle(20);
        chk("post_reset_exp", exp_cnt, 0);

        // Random starts/values with occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
